// File: rtl/booth_pkg.sv
// Shared encodings for the sequential Booth multiplier: controller state codes and status-bit indices.
// The optional BOOTH_EARLY_TERM_EN build uses ST_FINISH and the EARLY status bit.
package booth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHOOSE = 3'd1,
    ST_ADD    = 3'd2,
    ST_SUB    = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_FINISH = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam int Q0       = 0;
  localparam int QM1      = 1;
  localparam int LAST     = 2;
  localparam int EARLY    = 3;
  localparam int STATUS_W = 4;

endpackage

// File: rtl/booth_ctrl.sv
// Controller FSM for the Booth multiplier; busy/done decode from the state register.
// With BOOTH_EARLY_TERM_EN defined, CHOOSE can jump to FINISH when only shifts remain.
module booth_ctrl
  import booth_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [STATUS_W-1:0] status,
  output logic [2:0]          state,
  output logic                busy,
  output logic                done
);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = start ? ST_CHOOSE : ST_IDLE;
      ST_CHOOSE: begin
        case ({status[Q0], status[QM1]})
          2'b10:   state_d = ST_SUB;
          2'b01:   state_d = ST_ADD;
          default: state_d = ST_SHIFT;
        endcase
`ifdef BOOTH_EARLY_TERM_EN
        if (status[EARLY]) state_d = ST_FINISH;
`endif
      end
      ST_ADD:    state_d = ST_SHIFT;
      ST_SUB:    state_d = ST_SHIFT;
      ST_SHIFT:  state_d = status[LAST] ? ST_DONE : ST_CHOOSE;
`ifdef BOOTH_EARLY_TERM_EN
      ST_FINISH: state_d = ST_DONE;
`endif
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

`ifndef BOOTH_EARLY_TERM_EN
  logic unused_early;
  assign unused_early = status[EARLY];
`endif

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: A:Q:q-1 datapath on WIDTH+1 bits plus the booth_ctrl FSM.
// Optional feature macro: BOOTH_EARLY_TERM_EN (early exit through a one-cycle barrel shift).
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N     = WIDTH + 1;
  localparam int CNT_W = $clog2(N + 1);

  logic [2:0]          ctrl_state;
  state_t              state;
  logic [STATUS_W-1:0] status;
  logic                early;

  logic [N-1:0]         m_q, m_d, a_q, a_d, q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [N-1:0]         a_ext, b_ext;

  // One extra bit lets unsigned operands run through the signed algorithm unchanged.
  assign a_ext = {is_signed & a_in[WIDTH-1], a_in};
  assign b_ext = {is_signed & b_in[WIDTH-1], b_in};

`ifdef BOOTH_EARLY_TERM_EN
  logic [N-1:0]            rem_mask;
  logic [CNT_W-1:0]        shamt;
  logic signed [2*N-1:0]   aq_shr;

  // Low N-cnt bits of Q are the multiplier bits not yet consumed.
  assign rem_mask = {N{1'b1}} >> cnt_q;
  assign early    = (((q_q & rem_mask) == '0) && !qm1_q) ||
                    (((q_q | ~rem_mask) == {N{1'b1}}) && qm1_q);
  assign shamt    = CNT_W'(N) - cnt_q;
  assign aq_shr   = $signed({a_q, q_q}) >>> shamt;
`else
  assign early = 1'b0;
`endif

  assign status[Q0]    = q_q[0];
  assign status[QM1]   = qm1_q;
  assign status[LAST]  = (cnt_q == CNT_W'(N - 1));
  assign status[EARLY] = early;

  booth_ctrl u_ctrl (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .status (status),
    .state  (ctrl_state),
    .busy   (busy),
    .done   (done)
  );

  assign state = state_t'(ctrl_state);

  always_comb begin
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          m_d   = a_ext;
          q_d   = b_ext;
          a_d   = '0;
          qm1_d = 1'b0;
          cnt_d = '0;
        end
      end
      ST_ADD: a_d = a_q + m_q;
      ST_SUB: a_d = a_q - m_q;
      ST_SHIFT: begin
        {a_d, q_d, qm1_d} = {a_q[N-1], a_q, q_q};
        cnt_d = cnt_q + CNT_W'(1);
        // The top two bits of A only carry sign extension of the 2*WIDTH-bit result.
        if (status[LAST]) product_d = {a_d[N-3:0], q_d};
      end
`ifdef BOOTH_EARLY_TERM_EN
      ST_FINISH: begin
        {a_d, q_d} = aq_shr;
        cnt_d      = CNT_W'(N);
        product_d  = {a_d[N-3:0], q_d};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8): directed cases plus random vectors against
// an arithmetic product model and a Booth-recoding latency model (honours BOOTH_EARLY_TERM_EN).
module tb_booth_mult_seq;

  localparam int W = 8;
  localparam int N = W + 1;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic           is_signed = 1'b0;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .is_signed (is_signed),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] exp_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sgn);
    int x, y;
    x = sgn ? int'($signed(a)) : int'(a);
    y = sgn ? int'($signed(b)) : int'(b);
    return (2*W)'(x * y);
  endfunction

  // Walk the Booth digit pairs of the extended multiplier: a zero digit costs CHOOSE+SHIFT,
  // a nonzero digit costs CHOOSE+ADD/SUB+SHIFT, and DONE adds one cycle.
  function automatic int exp_latency(input logic [W-1:0] b, input logic sgn);
    logic [N:0] x;
    int t;
    x = {sgn & b[W-1], b, 1'b0};
    t = 0;
    for (int i = 0; i < N; i++) begin
`ifdef BOOTH_EARLY_TERM_EN
      begin
        bit uniform;
        uniform = 1'b1;
        for (int j = i + 1; j <= N; j++) if (x[j] != x[i]) uniform = 1'b0;
        if (uniform) return t + 3;
      end
`endif
      t += (x[i+1] != x[i]) ? 3 : 2;
    end
    return t + 1;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       output logic [2*W-1:0] prod, output int lat, output logic pulse_ok);
    int cyc;
    @(negedge clk);
    a_in = a; b_in = b; is_signed = sgn; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; lat = -1; prod = '0;
    while (lat < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        lat  = cyc;
        prod = product;
      end
    end
    @(negedge clk);
    pulse_ok = (lat >= 0) && !done && !busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (product !== '0) $display("FAIL reset_product: got %h expected 0000", product); else n_pass++;
    $display("reset: busy=%b done=%b product=%h", busy, done, product);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0]   ta [4] = '{8'hFD, 8'd255, 8'h80, 8'h80};
    logic [W-1:0]   tb [4] = '{8'd5,  8'd255, 8'h80, 8'd127};
    logic           ts [4] = '{1'b1,  1'b0,   1'b1,  1'b1};
    logic [2*W-1:0] te [4] = '{16'hFFF1, 16'hFE01, 16'h4000, 16'hC080};
    logic [2*W-1:0] p;
    int lat, el;
    logic ok;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], ts[i], p, lat, ok);
      el = exp_latency(tb[i], ts[i]);
      $display("directed: a=%h b=%h s=%b product=%h latency=%0d", ta[i], tb[i], ts[i], p, lat);
      n_checks++; if (p !== te[i]) $display("FAIL directed_product[%0d]: got %h expected %h", i, p, te[i]); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, el); else n_pass++;
      n_checks++; if (ok !== 1'b1) $display("FAIL directed_pulse[%0d]: got %b expected 1", i, ok); else n_pass++;
    end
  endtask

  task automatic test_zero_b();
    logic [2*W-1:0] p;
    int lat, el;
    logic ok;
`ifdef BOOTH_EARLY_TERM_EN
    el = 3;
`else
    el = 2*N + 1;
`endif
    for (int s = 0; s < 2; s++) begin
      do_op(8'd77, 8'd0, 1'(s), p, lat, ok);
      $display("zero_b: s=%0d product=%h latency=%0d", s, p, lat);
      n_checks++; if (p !== '0) $display("FAIL zero_product: got %h expected 0000", p); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL zero_latency: got %0d expected %0d", lat, el); else n_pass++;
    end
  endtask

  task automatic test_start_held();
    int cyc;
    @(negedge clk);
    a_in = 8'd5; b_in = 8'd7; is_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    n_checks++; if (busy !== 1'b1) $display("FAIL held_busy_on: got %b expected 1", busy); else n_pass++;
    a_in = 8'd200; b_in = 8'd3; is_signed = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    $display("held: first product=%h latency=%0d", product, cyc);
    n_checks++; if (product !== 16'd35) $display("FAIL held_first_product: got %h expected %h", product, 16'd35); else n_pass++;
    n_checks++; if (cyc != exp_latency(8'd7, 1'b1)) $display("FAIL held_first_latency: got %0d expected %0d", cyc, exp_latency(8'd7, 1'b1)); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL held_idle_gap: got busy=%b expected 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL held_second_accept: got busy=%b expected 1", busy); else n_pass++;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    $display("held: second product=%h", product);
    n_checks++; if (product !== 16'd600) $display("FAIL held_second_product: got %h expected %h", product, 16'd600); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] p;
    int lat;
    logic ok;
    do_op(8'hFD, 8'd5, 1'b1, p, lat, ok);
    n_checks++; if (p !== 16'hFFF1) $display("FAIL rmid_pre_product: got %h expected FFF1", p); else n_pass++;
    @(negedge clk);
    a_in = 8'hFD; b_in = 8'd5; is_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    $display("reset_mid: busy=%b done=%b product=%h", busy, done, product);
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rmid_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (product !== '0) $display("FAIL rmid_product: got %h expected 0000", product); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    do_op(8'd100, 8'd3, 1'b0, p, lat, ok);
    $display("reset_mid: after product=%h", p);
    n_checks++; if (p !== 16'd300) $display("FAIL rmid_after_product: got %h expected %h", p, 16'd300); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic           s;
    logic [2*W-1:0] p, ep;
    int lat, el;
    logic ok;
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      b = (i % 10 == 0) ? W'($urandom_range(3, 0)) : W'($urandom);
      s = 1'($urandom);
      do_op(a, b, s, p, lat, ok);
      ep = exp_product(a, b, s);
      el = exp_latency(b, s);
      $display("random[%0d]: a=%h b=%h s=%b product=%h latency=%0d", i, a, b, s, p, lat);
      n_checks++; if (p !== ep) $display("FAIL rand_product[%0d]: got %h expected %h", i, p, ep); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, el); else n_pass++;
      n_checks++; if (ok !== 1'b1) $display("FAIL rand_pulse[%0d]: got %b expected 1", i, ok); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_b();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
